game_turn_controller: RTL
=========================

# game_turn_controller

Sequencing controller for the two-player board game datapath. Conditions the five raw push-buttons, arbitrates same-cycle presses, moves a wrapping cursor over the board, and issues one placement request per accepted Select to the game datapath over a req/ack handshake. It alternates turns, enforces a per-turn timeout, and freezes on game over. It sits between the board buttons and the game-state/board module.

## Interface
Parameters:
- ROWS, 3: board rows (≥2)
- COLS, 3: board columns (≥2)
- DEBOUNCE_CYCLES, 4: consecutive stable-high synchronized samples needed to register a press (≥1)
- TURN_TIMEOUT, 1500: idle cycles in WAIT_INPUT before the turn is forfeited (≥2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- btnLeft, btnRight, btnUp, btnDown, btnSelect  in  1 each  raw active-high buttons
- cell_busy  in  1  datapath: cell at (cursor_row, cursor_col) is occupied
- place_ack  in  1  datapath accepted the placement
- game_over  in  1  datapath: win or draw reached
- cursor_row  out  $clog2(ROWS)  cursor row
- cursor_col  out  $clog2(COLS)  cursor column
- place_req  out  1  placement request, held until ack
- place_player  out  1  player owning the request
- current_player  out  1  player whose turn it is (0 or 1)
- reject  out  1  one-cycle pulse: Select on a busy cell
- timeout  out  1  one-cycle pulse: turn forfeited
- done  out  1  game frozen

## Operation
- Reset (rst=0 at an edge): cursor (0,0), current_player 0, place_req/place_player/reject/timeout/done 0, state WAIT_INPUT, timeout counter 0, all debouncers cleared. Applies mid-handshake: place_req drops at that edge, and no placement is counted.
- Each button: 2-flop synchronizer, then a saturating counter. The stable level rises after DEBOUNCE_CYCLES consecutive high samples and falls on the first low sample. A press is the rising edge of the stable level, one cycle wide. Holding a button produces a single press.
- Arbitration, one action per cycle, priority Select > Up > Down > Left > Right. Lower-priority presses in the same cycle are discarded, not queued.
- States:
  - WAIT_INPUT: handles presses.
    - Up/Down: row −1/+1 with wrap (0→ROWS−1, ROWS−1→0).
    - Left/Right: column −1/+1 with wrap.
    - Select with cell_busy=1: reject pulse, stay in WAIT_INPUT.
    - Select with cell_busy=0: go to PLACE.
  - PLACE: place_req=1 and place_player=current_player. Cursor is frozen and presses are ignored. place_ack=1 at an edge drops req and goes to SWITCH.
  - SWITCH: if game_over=1, go to DONE. Otherwise toggle current_player, return to WAIT_INPUT, counter 0.
  - DONE: done=1 and all buttons ignored until reset.
- Timeout counter runs only in WAIT_INPUT and clears on any accepted press, including a rejected Select. When it reaches TURN_TIMEOUT−1: timeout pulse, toggle player, counter 0, cursor unchanged.
- A press coinciding with the timeout cycle: the press wins and no timeout occurs.
- game_over sampled in WAIT_INPUT also goes to DONE, with no toggle.

## Timing
- Raw button high from edge k, held: cursor/state update at edge k+DEBOUNCE_CYCLES+3.
- Select→place_req: same latency; req asserted in the cycle after the Select press registers.
- place_ack with req=1 at edge m: req=0 after m; current_player toggles at edge m+1.
- Ack already high when req rises: accepted at the first edge with req=1, so req lasts exactly 1 cycle.
- reject/timeout are exactly 1 cycle wide. All outputs are registered.

## Structure
- Package game_pkg: state enum (WAIT_INPUT, PLACE, SWITCH, DONE) and button index constants/priority order. The game datapath imports the same package.
- Sub-module btn_debounce (synchronizer + counter + edge detect, parameter DEBOUNCE_CYCLES), instantiated five times.

## Test plan
Bench uses DEBOUNCE_CYCLES=2, TURN_TIMEOUT=20.
- btnDown held 6 cycles from reset → cursor_row 0→1 at edge 5 (2+3), exactly once; a second press gives 2, a third wraps to 0.
- btnLeft at (0,0) → cursor_col=2. btnLeft+btnUp pressed in the same cycle → only row changes to 2, col unchanged.
- Select on a free cell, ack delayed 3 cycles → place_req high 3 cycles with place_player=0, then current_player=1. Select with cell_busy=1 → reject one cycle, no req, player unchanged.
- No presses for 20 cycles → timeout pulse at cycle 19, current_player toggles, counter restarts. A press at cycle 19 → no timeout.
- rst=0 during PLACE with req high → req=0, cursor (0,0), player 0 after that edge; no toggle when ack later arrives.
- game_over=1 in SWITCH → done=1, no toggle; subsequent button presses leave cursor and player unchanged.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the board game: turn FSM states, button indices
// and the same-cycle button arbitration order.
package game_pkg;

    typedef enum logic [1:0] {
        WAIT_INPUT = 2'd0,
        PLACE      = 2'd1,
        SWITCH     = 2'd2,
        DONE       = 2'd3
    } gameState_t;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_SELECT = 3'd1,
        ACT_UP     = 3'd2,
        ACT_DOWN   = 3'd3,
        ACT_LEFT   = 3'd4,
        ACT_RIGHT  = 3'd5
    } action_t;

    localparam int NUM_BTNS   = 5;
    localparam int BTN_SELECT = 0;
    localparam int BTN_UP     = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 3;
    localparam int BTN_RIGHT  = 4;

    // Highest-priority press wins; the rest are dropped, not queued.
    function automatic action_t arbitrate(input logic [NUM_BTNS-1:0] p);
        action_t a;
        a = ACT_NONE;
        if (p[BTN_SELECT])     a = ACT_SELECT;
        else if (p[BTN_UP])    a = ACT_UP;
        else if (p[BTN_DOWN])  a = ACT_DOWN;
        else if (p[BTN_LEFT])  a = ACT_LEFT;
        else if (p[BTN_RIGHT]) a = ACT_RIGHT;
        return a;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, saturating stable counter,
// registered one-cycle pulse on the rising edge of the stable level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btnRaw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          syncA;
    logic          syncB;
    logic          stable;
    logic          stableQ;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            syncA   <= 1'b0;
            syncB   <= 1'b0;
            stable  <= 1'b0;
            stableQ <= 1'b0;
            count   <= '0;
            press   <= 1'b0;
        end else begin
            syncA   <= btnRaw;
            syncB   <= syncA;
            stableQ <= stable;
            press   <= stable & ~stableQ;
            if (!syncB) begin
                count  <= '0;
                stable <= 1'b0;
            end else if (count != CNT_MAX) begin
                count <= count + 1'b1;
                if (count == CNT_MAX - 1'b1) stable <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_turn_controller.sv
// Turn sequencer: debounced buttons drive a wrapping cursor and a
// req/ack placement handshake, with turn timeout and game-over freeze.
module game_turn_controller
    import game_pkg::*;
#(
    parameter int ROWS            = 3,
    parameter int COLS            = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TURN_TIMEOUT    = 1500
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btnLeft,
    input  logic                     btnRight,
    input  logic                     btnUp,
    input  logic                     btnDown,
    input  logic                     btnSelect,
    input  logic                     cell_busy,
    input  logic                     place_ack,
    input  logic                     game_over,
    output logic [$clog2(ROWS)-1:0]  cursor_row,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic                     place_req,
    output logic                     place_player,
    output logic                     current_player,
    output logic                     reject,
    output logic                     timeout,
    output logic                     done
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int TW = $clog2(TURN_TIMEOUT);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TURN_TIMEOUT - 1);

    logic [NUM_BTNS-1:0] btnRaw;
    logic [NUM_BTNS-1:0] press;
    action_t             action;

    gameState_t    state, stateNext;
    logic [RW-1:0] rowNext;
    logic [CW-1:0] colNext;
    logic [TW-1:0] timer, timerNext;
    logic          playerNext;
    logic          reqNext;
    logic          placePlayerNext;
    logic          rejectNext;
    logic          timeoutNext;
    logic          doneNext;

    assign btnRaw[BTN_SELECT] = btnSelect;
    assign btnRaw[BTN_UP]     = btnUp;
    assign btnRaw[BTN_DOWN]   = btnDown;
    assign btnRaw[BTN_LEFT]   = btnLeft;
    assign btnRaw[BTN_RIGHT]  = btnRight;

    genvar i;
    generate
        for (i = 0; i < NUM_BTNS; i++) begin : gDeb
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) uDeb (
                .clk   (clk),
                .rst   (rst),
                .btnRaw(btnRaw[i]),
                .press (press[i])
            );
        end
    endgenerate

    assign action = arbitrate(press);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= WAIT_INPUT;
            timer          <= '0;
            cursor_row     <= '0;
            cursor_col     <= '0;
            current_player <= 1'b0;
            place_req      <= 1'b0;
            place_player   <= 1'b0;
            reject         <= 1'b0;
            timeout        <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= stateNext;
            timer          <= timerNext;
            cursor_row     <= rowNext;
            cursor_col     <= colNext;
            current_player <= playerNext;
            place_req      <= reqNext;
            place_player   <= placePlayerNext;
            reject         <= rejectNext;
            timeout        <= timeoutNext;
            done           <= doneNext;
        end
    end

    always_comb begin
        stateNext   = state;
        timerNext   = timer;
        rowNext     = cursor_row;
        colNext     = cursor_col;
        playerNext  = current_player;
        reqNext     = 1'b0;
        rejectNext  = 1'b0;
        timeoutNext = 1'b0;
        doneNext    = 1'b0;
        unique case (state)
            WAIT_INPUT: begin
                if (game_over) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end else if (action != ACT_NONE) begin
                    // Any accepted press, even a rejected Select, restarts the turn timer.
                    timerNext = '0;
                    unique case (action)
                        ACT_SELECT: begin
                            if (cell_busy) begin
                                rejectNext = 1'b1;
                            end else begin
                                stateNext = PLACE;
                                reqNext   = 1'b1;
                            end
                        end
                        ACT_UP:
                            rowNext = (cursor_row == '0) ? ROW_LAST : cursor_row - 1'b1;
                        ACT_DOWN:
                            rowNext = (cursor_row == ROW_LAST) ? '0 : cursor_row + 1'b1;
                        ACT_LEFT:
                            colNext = (cursor_col == '0) ? COL_LAST : cursor_col - 1'b1;
                        ACT_RIGHT:
                            colNext = (cursor_col == COL_LAST) ? '0 : cursor_col + 1'b1;
                        default: ;
                    endcase
                end else if (timer == TO_LAST) begin
                    timeoutNext = 1'b1;
                    playerNext  = ~current_player;
                    timerNext   = '0;
                end else begin
                    timerNext = timer + 1'b1;
                end
            end
            PLACE: begin
                if (place_ack) stateNext = SWITCH;
                else           reqNext   = 1'b1;
            end
            SWITCH: begin
                if (game_over) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end else begin
                    stateNext  = WAIT_INPUT;
                    playerNext = ~current_player;
                    timerNext  = '0;
                end
            end
            DONE: begin
                doneNext = 1'b1;
            end
            default: begin
                stateNext = WAIT_INPUT;
            end
        endcase
    end

    assign placePlayerNext = reqNext ? current_player : 1'b0;

endmodule
